// File: rtl/var_delay_line_pkg.sv
// var_delay_line_pkg: shared types and helpers for the variable delay line.
// Holds the fill/run state enum, the delay-field width derivation and clamp.
package var_delay_line_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width needed to hold a delay value in the range 0..max_len.
    function automatic int unsigned dw_of(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // A zero request means "minimum delay"; oversize requests saturate.
    function automatic int unsigned clamp_dly(
        input int unsigned req,
        input int unsigned max_len
    );
        if (req == 0) begin
            return 1;
        end
        if (req > max_len) begin
            return max_len;
        end
        return req;
    endfunction

endpackage

// File: rtl/var_delay_ram.sv
// var_delay_ram: DEPTH x WIDTH circular sample store, sync write, async read.
// Ports: i_clk, i_we, i_waddr, i_wdata (write side); i_raddr -> o_rdata (read).
module var_delay_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/var_delay_line.sv
// var_delay_line: run-time programmable 1..MAX_LEN cycle delay with valid tags.
// Ports: CLK_I, RSTN_I (async low); IN_I/IN_VLD_I sample in; DLY_I/DLY_LD_I
// delay load; OUT_O/OUT_VLD_O delayed sample; CUR_DLY_O delay; BUSY_O refill.
module var_delay_line
    import var_delay_line_pkg::*;
#(
    parameter int  WIDTH    = 8,
    parameter int  MAX_LEN  = 16,
    parameter int  INIT_LEN = 3,
    localparam int DW       = dw_of(MAX_LEN)
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic [WIDTH-1:0] IN_I,
    input  logic             IN_VLD_I,
    input  logic [DW-1:0]    DLY_I,
    input  logic             DLY_LD_I,
    output logic [WIDTH-1:0] OUT_O,
    output logic             OUT_VLD_O,
    output logic [DW-1:0]    CUR_DLY_O,
    output logic             BUSY_O
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [AW-1:0]      r_wp;
    logic [MAX_LEN-1:0] r_vld;
    logic [DW-1:0]      r_cur;
    logic [DW-1:0]      r_cnt;
    state_t             r_state;
    logic               r_busy;
    logic [WIDTH-1:0]   r_out;
    logic               r_out_vld;

    logic [AW-1:0]      w_wp_nxt;
    logic [DW-1:0]      w_dm1;
    logic [DW:0]        w_rp_sum;
    logic [DW:0]        w_rp_wrap;
    logic [AW-1:0]      w_rp;
    logic [WIDTH-1:0]   w_rdata;
    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_vld;
    logic [DW-1:0]      w_new_dly;
    logic [DW-1:0]      w_cnt_nxt;

    var_delay_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_LEN)
    ) u_ram (
        .i_clk   (CLK_I),
        .i_we    (RSTN_I),
        .i_waddr (r_wp),
        .i_wdata (IN_I),
        .i_raddr (w_rp),
        .o_rdata (w_rdata)
    );

    assign w_wp_nxt = (r_wp == AW'(MAX_LEN - 1)) ? '0 : r_wp + AW'(1);

    // Read slot is (wp - (d-1)) mod MAX_LEN; biased by MAX_LEN so the
    // subtraction never underflows, then folded back with one compare.
    assign w_dm1     = r_cur - DW'(1);
    assign w_rp_sum  = (DW+1)'(r_wp) + (DW+1)'(MAX_LEN) - (DW+1)'(w_dm1);
    assign w_rp_wrap = (w_rp_sum >= (DW+1)'(MAX_LEN))
                     ? w_rp_sum - (DW+1)'(MAX_LEN)
                     : w_rp_sum;
    assign w_rp      = AW'(w_rp_wrap);

    assign w_new_dly = DW'(clamp_dly(32'(DLY_I), MAX_LEN));
    assign w_cnt_nxt = r_cnt + DW'(1);

    // A load edge always emits an invalid slot. Invalid slots carry zero
    // data so unwritten RAM words can never leak X onto OUT_O.
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_data = '0;
        if (r_cur == DW'(1)) begin
            w_sel_vld  = IN_VLD_I;
            w_sel_data = IN_I;
        end else begin
            w_sel_vld  = r_vld[w_rp];
            w_sel_data = w_rdata;
        end
        if (DLY_LD_I) begin
            w_sel_vld = 1'b0;
        end
        if (!w_sel_vld) begin
            w_sel_data = '0;
        end
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_wp      <= '0;
            r_vld     <= '0;
            r_cur     <= DW'(INIT_LEN);
            r_cnt     <= '0;
            r_state   <= FILL;
            r_busy    <= 1'b1;
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_wp      <= w_wp_nxt;
            r_out     <= w_sel_data;
            r_out_vld <= w_sel_vld;
            if (DLY_LD_I) begin
                // Flush stale tags; the sample written now is the first
                // one that belongs to the new delay.
                r_vld       <= '0;
                r_vld[r_wp] <= IN_VLD_I;
                r_cur       <= w_new_dly;
                r_cnt       <= '0;
                r_state     <= FILL;
                r_busy      <= 1'b1;
            end else begin
                r_vld[r_wp] <= IN_VLD_I;
                unique case (r_state)
                    FILL: begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt >= w_dm1) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                        end
                    end
                    RUN: begin
                        r_state <= RUN;
                    end
                endcase
            end
        end
    end

    assign OUT_O     = r_out;
    assign OUT_VLD_O = r_out_vld;
    assign CUR_DLY_O = r_cur;
    assign BUSY_O    = r_busy;

endmodule
